// File: rtl/m_stage.sv
// Memory stage: E/M registers in, load/store over a req/ack bus, aligned load data and M/W registers out.
// Latency 1 cycle for non-mem ops and zero-wait accesses, N+1 with N wait states; stall freezes upstream while waiting.
module m_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic [31:0] pc,
    input  logic [6:0]  m_con_in,
    input  logic [5:0]  w_con_in,
    input  logic [4:0]  em_rs2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        em_regfile_we,
    output logic [4:0]  em_rd,
    output logic [31:0] em_data,
    output logic        mw_regfile_we,
    output logic [4:0]  mw_rd,
    output logic [31:0] mw_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] err_pc
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] sd_q, sd_d;
    logic        mw_we_q, mw_we_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic [31:0] mw_data_q, mw_data_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_pc_q, err_pc_d;

    logic [1:0]  size;
    logic        is_unsigned, is_load, is_store, mem_op, misalign;
    logic [31:0] sd_fwd, sd, rdata_sh, load_val;
    logic        req_raw, stall_raw, abort;

    wire unused_mcon = &{1'b0, m_con_in[6:5]};

    assign size        = m_con_in[1:0];
    assign is_unsigned = m_con_in[2];
    assign is_load     = m_con_in[3];
    assign is_store    = m_con_in[4];
    assign mem_op      = is_load | is_store;
    assign misalign    = mem_op && ((size == 2'b01 && alu_result[0]) ||
                                    (size[1] && alu_result[1:0] != 2'b00));

    assign em_regfile_we = w_con_in[5];
    assign em_rd         = w_con_in[4:0];
    assign em_data       = alu_result;

    // Store data is latched on entry to WAIT: the bubble written into M/W would otherwise kill the forward.
    assign sd_fwd = (mw_we_q && mw_rd_q != 5'd0 && mw_rd_q == em_rs2) ? mw_data_q : write_data;
    assign sd     = (state_q == WAIT) ? sd_q : sd_fwd;

    assign dmem_addr = {alu_result[31:2], 2'b00};
    assign dmem_we   = is_store && dmem_req;

    always_comb begin
        dmem_wdata = sd;
        dmem_be    = 4'b1111;
        if (is_store) begin
            case (size)
                2'b00: begin
                    dmem_wdata = {4{sd[7:0]}};
                    dmem_be    = 4'b0001 << alu_result[1:0];
                end
                2'b01: begin
                    dmem_wdata = {2{sd[15:0]}};
                    dmem_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    dmem_wdata = sd;
                    dmem_be    = 4'b1111;
                end
            endcase
        end
    end

    assign rdata_sh = dmem_rdata >> {alu_result[1:0], 3'b000};

    always_comb begin
        case (size)
            2'b00:   load_val = is_unsigned ? {24'd0, rdata_sh[7:0]}
                                            : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_val = is_unsigned ? {16'd0, rdata_sh[15:0]}
                                            : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            default: load_val = rdata_sh;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !misalign && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end
            end
            WAIT: begin
                if (dmem_ack || cnt_q == TO) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = 8'(cnt_q + 8'd1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                req_raw   = mem_op && !misalign;
                stall_raw = mem_op && !misalign && !dmem_ack;
            end
            WAIT: begin
                req_raw   = 1'b1;
                stall_raw = !dmem_ack && cnt_q != TO;
                abort     = !dmem_ack && cnt_q == TO;
            end
            default: ;
        endcase
        dmem_req = req_raw && !rst;
        stall    = stall_raw && !rst;
    end

    always_comb begin
        mw_we_d      = mw_we_q;
        mw_rd_d      = mw_rd_q;
        mw_data_d    = mw_data_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        err_pc_d     = err_pc_q;
        sd_d         = (state_q == IDLE) ? sd_fwd : sd_q;
        if (state_q == IDLE && misalign) begin
            mw_we_d      = 1'b0;
            misaligned_d = 1'b1;
            err_pc_d     = pc;
        end else if (abort) begin
            mw_we_d   = 1'b0;
            bus_err_d = 1'b1;
            err_pc_d  = pc;
        end else if (stall_raw) begin
            mw_we_d = 1'b0;
        end else begin
            mw_we_d   = w_con_in[5];
            mw_rd_d   = w_con_in[4:0];
            mw_data_d = is_load ? load_val : alu_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sd_q         <= 32'd0;
            mw_we_q      <= 1'b0;
            mw_rd_q      <= 5'd0;
            mw_data_q    <= 32'd0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
            err_pc_q     <= 32'd0;
        end else begin
            sd_q         <= sd_d;
            mw_we_q      <= mw_we_d;
            mw_rd_q      <= mw_rd_d;
            mw_data_q    <= mw_data_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
            err_pc_q     <= err_pc_d;
        end
    end

    assign mw_regfile_we = mw_we_q;
    assign mw_rd         = mw_rd_q;
    assign mw_data       = mw_data_q;
    assign misaligned    = misaligned_q;
    assign bus_err       = bus_err_q;
    assign err_pc        = err_pc_q;

endmodule

// File: tb/tb_m_stage.sv
// Bench for m_stage: writebacks go through a scoreboard queue, bus/stall/error behaviour checked inline per scenario.
module tb_m_stage;

    logic        clk, rst;
    logic [31:0] alu_result, write_data, pc;
    logic [6:0]  m_con_in;
    logic [5:0]  w_con_in;
    logic [4:0]  em_rs2;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, em_regfile_we, mw_regfile_we, misaligned, bus_err;
    logic [4:0]  em_rd, mw_rd;
    logic [31:0] em_data, mw_data, err_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;
    wb_t exp_q[$];

    m_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_result(alu_result), .write_data(write_data), .pc(pc),
        .m_con_in(m_con_in), .w_con_in(w_con_in), .em_rs2(em_rs2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall),
        .em_regfile_we(em_regfile_we), .em_rd(em_rd), .em_data(em_data),
        .mw_regfile_we(mw_regfile_we), .mw_rd(mw_rd), .mw_data(mw_data),
        .misaligned(misaligned), .bus_err(bus_err), .err_pc(err_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Every writeback the DUT performs must match the oldest expected one.
    always @(posedge clk) begin
        #1;
        if (mw_regfile_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback", mw_rd, mw_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (mw_rd !== e.rd || mw_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_data: got rd=%0d data=%h, expected rd=%0d data=%h",
                             mw_rd, mw_data, e.rd, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] p,
                            input logic [6:0] mc, input logic [5:0] wc, input logic [4:0] rs2);
        alu_result = a;
        write_data = wd;
        pc         = p;
        m_con_in   = mc;
        w_con_in   = wc;
        em_rs2     = rs2;
    endtask

    task automatic drive_idle();
        drive_op(32'd0, 32'd0, 32'd0, 7'h00, 6'h00, 5'd0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        drive_op(32'h100, 32'd0, 32'h40, 7'h0A, 6'h21, 5'd0);
        #3;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", dmem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
        checks++; if ({mw_regfile_we, mw_rd, mw_data} !== 38'd0) begin errors++;
            $display("FAIL rst_mw: got we=%b rd=%0d data=%h expected all 0", mw_regfile_we, mw_rd, mw_data); end
        checks++; if ({misaligned, bus_err, err_pc} !== 34'd0) begin errors++;
            $display("FAIL rst_err: got mis=%b berr=%b err_pc=%h expected all 0", misaligned, bus_err, err_pc); end
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu();
        drive_op(32'h1234, 32'd0, 32'h44, 7'h00, 6'h23, 5'd0);
        exp_q.push_back('{rd: 5'd3, data: 32'h1234});
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req: got %b expected 0", dmem_req); end
        checks++; if ({em_regfile_we, em_rd, em_data} !== {1'b1, 5'd3, 32'h1234}) begin errors++;
            $display("FAIL alu_em_fwd: got we=%b rd=%0d data=%h expected 1/3/00001234", em_regfile_we, em_rd, em_data); end
        tick();
        checks++; if ({mw_regfile_we, mw_rd, mw_data} !== {1'b1, 5'd3, 32'h1234}) begin errors++;
            $display("FAIL alu_mw: got we=%b rd=%0d data=%h expected 1/3/00001234", mw_regfile_we, mw_rd, mw_data); end
        drive_idle();
        tick();
    endtask

    task automatic test_lb_zero_wait();
        drive_op(32'h103, 32'd0, 32'h48, 7'h08, 6'h27, 5'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h80FF_FFFF;
        exp_q.push_back('{rd: 5'd7, data: 32'hFFFF_FF80});
        #1;
        checks++; if ({dmem_req, dmem_we, stall} !== 3'b100) begin errors++;
            $display("FAIL lb_bus: got req=%b we=%b stall=%b expected 1/0/0", dmem_req, dmem_we, stall); end
        checks++; if ({dmem_addr, dmem_be} !== {32'h100, 4'b1111}) begin errors++;
            $display("FAIL lb_addr_be: got %h/%b expected 00000100/1111", dmem_addr, dmem_be); end
        tick();
        drive_idle();
        checks++; if (mw_data !== 32'hFFFF_FF80) begin errors++;
            $display("FAIL lb_data: got %h expected ffffff80", mw_data); end
        tick();
    endtask

    task automatic test_lhu_wait();
        int n_stall = 0;
        drive_op(32'h102, 32'd0, 32'h4C, 7'h0D, 6'h28, 5'd0);
        exp_q.push_back('{rd: 5'd8, data: 32'h0000_BEEF});
        for (int i = 0; i < 3; i++) begin
            #1;
            if (stall === 1'b1 && dmem_req === 1'b1) n_stall++;
            tick();
            checks++; if (mw_regfile_we !== 1'b0) begin errors++;
                $display("FAIL lhu_bubble: cycle %0d got we=%b expected 0", i, mw_regfile_we); end
        end
        checks++; if (n_stall !== 3) begin errors++;
            $display("FAIL lhu_stall_cnt: got %0d expected 3", n_stall); end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hBEEF_0000;
        #1;
        checks++; if ({dmem_req, stall} !== 2'b10) begin errors++;
            $display("FAIL lhu_ack_cycle: got req=%b stall=%b expected 1/0", dmem_req, stall); end
        tick();
        drive_idle();
        checks++; if (mw_data !== 32'h0000_BEEF) begin errors++;
            $display("FAIL lhu_data: got %h expected 0000beef", mw_data); end
        tick();
    endtask

    task automatic test_store();
        drive_op(32'hCD, 32'd0, 32'h50, 7'h00, 6'h25, 5'd0);
        exp_q.push_back('{rd: 5'd5, data: 32'hCD});
        tick();
        drive_op(32'h101, 32'hAB, 32'h54, 7'h10, 6'h00, 5'd5);
        dmem_ack = 1'b1;
        #1;
        checks++; if ({dmem_req, dmem_we, dmem_be} !== {2'b11, 4'b0010}) begin errors++;
            $display("FAIL sb_bus: got req=%b we=%b be=%b expected 1/1/0010", dmem_req, dmem_we, dmem_be); end
        checks++; if (dmem_wdata !== 32'hCDCD_CDCD) begin errors++;
            $display("FAIL sb_fwd_wdata: got %h expected cdcdcdcd", dmem_wdata); end
        tick();
        drive_op(32'h102, 32'h1234, 32'h58, 7'h11, 6'h00, 5'd6);
        #1;
        checks++; if ({dmem_wdata, dmem_be} !== {32'h1234_1234, 4'b1100}) begin errors++;
            $display("FAIL sh_wdata_be: got %h/%b expected 12341234/1100", dmem_wdata, dmem_be); end
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_lw_misaligned();
        drive_op(32'h102, 32'd0, 32'h400, 7'h0A, 6'h29, 5'd0);
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin errors++;
            $display("FAIL mis_req: got req=%b stall=%b expected 0/0", dmem_req, stall); end
        tick();
        drive_idle();
        checks++; if ({misaligned, err_pc, mw_regfile_we} !== {1'b1, 32'h400, 1'b0}) begin errors++;
            $display("FAIL mis_pulse: got mis=%b err_pc=%h we=%b expected 1/00000400/0", misaligned, err_pc, mw_regfile_we); end
        tick();
        checks++; if (misaligned !== 1'b0) begin errors++;
            $display("FAIL mis_one_cycle: got %b expected 0", misaligned); end
    endtask

    task automatic test_timeout();
        int n_stall = 0;
        drive_op(32'h200, 32'd0, 32'h500, 7'h0A, 6'h2A, 5'd0);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (stall !== 1'b1) break;
            n_stall++;
            tick();
        end
        checks++; if (n_stall !== 4) begin errors++;
            $display("FAIL to_stall_cnt: got %0d expected 4", n_stall); end
        tick();
        drive_idle();
        #1;
        checks++; if ({bus_err, err_pc, mw_regfile_we} !== {1'b1, 32'h500, 1'b0}) begin errors++;
            $display("FAIL to_bus_err: got berr=%b err_pc=%h we=%b expected 1/00000500/0", bus_err, err_pc, mw_regfile_we); end
        checks++; if (dmem_req !== 1'b0) begin errors++;
            $display("FAIL to_req_drop: got %b expected 0", dmem_req); end
        tick();
        checks++; if (bus_err !== 1'b0) begin errors++;
            $display("FAIL to_one_cycle: got %b expected 0", bus_err); end
    endtask

    task automatic test_rst_mid_wait();
        drive_op(32'h300, 32'd0, 32'h600, 7'h0A, 6'h2B, 5'd0);
        tick();
        checks++; if (stall !== 1'b1) begin errors++;
            $display("FAIL rmw_waiting: got stall=%b expected 1", stall); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin errors++;
            $display("FAIL rmw_req_async: got req=%b stall=%b expected 0/0", dmem_req, stall); end
        checks++; if (err_pc !== 32'd0) begin errors++;
            $display("FAIL rmw_err_pc: got %h expected 0", err_pc); end
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({dmem_req, stall} !== 2'b00) begin errors++;
            $display("FAIL rmw_late_ack: got req=%b stall=%b expected 0/0", dmem_req, stall); end
        tick();
        dmem_ack = 1'b0;
        checks++; if (mw_regfile_we !== 1'b0) begin errors++;
            $display("FAIL rmw_no_wb: got we=%b expected 0", mw_regfile_we); end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_zero_wait();
        test_lhu_wait();
        test_store();
        test_lw_misaligned();
        test_timeout();
        test_rst_mid_wait();
        tick();
        checks++; if (exp_q.size() !== 0) begin errors++;
            $display("FAIL sb_drain: got %0d pending writebacks expected 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
